// File: rtl/data_packetizer_pkg.sv
// Shared packet definitions for the packetizer and the host-side decoder model.
// Packet: SYNC, SEQ, LEN, LEN payload bytes, CHK (mod-256 sum of SEQ, LEN and payload).
package data_packetizer_pkg;

  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FILL,
    ST_HDR,
    ST_SEQ,
    ST_LEN,
    ST_PAYLOAD,
    ST_CHK
  } pktState_t;

  // Field order on the wire; a decoder walks these in sequence.
  typedef enum logic [2:0] {
    FIELD_SYNC,
    FIELD_SEQ,
    FIELD_LEN,
    FIELD_PAYLOAD,
    FIELD_CHK
  } pktField_t;

  localparam int HDR_BYTES     = 3;
  localparam int TRAILER_BYTES = 1;

  function automatic logic [7:0] chkAdd(input logic [7:0] acc, input logic [7:0] b);
    return acc + b;
  endfunction

endpackage

// File: rtl/data_packetizer_buffer.sv
// Payload store for one packet: one write port, registered read port (1-cycle latency).
// Contents are not reset; no flow control of its own.
module packet_buffer #(
  parameter int DEPTH = 64,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          Clock,
  input  logic          WriteEnable,
  input  logic [AW-1:0] WriteAddr,
  input  logic [7:0]    WriteData,
  input  logic [AW-1:0] ReadAddr,
  output logic [7:0]    ReadData
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge Clock) begin
    if (WriteEnable) mem[WriteAddr] <= WriteData;
    ReadData <= mem[ReadAddr];
  end

endmodule

// File: rtl/data_packetizer.sv
// Buffers up to PAYLOAD_MAX storage bytes, then frames them as SYNC/SEQ/LEN/payload/CHK.
// LEN+4 back-to-back Tx cycles per packet when TxReady stays high; Tx holds its byte while TxReady is low.
module data_packetizer
  import data_packetizer_pkg::*;
#(
  parameter int         PAYLOAD_MAX = 64,
  parameter logic [7:0] SYNC_BYTE   = DEFAULT_SYNC_BYTE
) (
  input  logic       Clock,
  input  logic       Reset_n,
  input  logic       DataReadyToSend,
  input  logic [7:0] DataIn,
  input  logic       DataValid,
  output logic       ReadEnable,
  output logic [7:0] TxData,
  output logic       TxValid,
  input  logic       TxReady,
  output logic       Busy
);

  localparam int         AW     = (PAYLOAD_MAX > 1) ? $clog2(PAYLOAD_MAX) : 1;
  localparam logic [7:0] MaxLen = 8'(PAYLOAD_MAX);

  pktState_t  state, stateNext;
  logic [7:0] seqNum, wrCount, checksum;
  logic [7:0] rdIdx, rdIdxNext;
  logic [7:0] txDataNext, bufData;
  logic       pending, bufWrite, packetDone, fillDone, fillEmpty;

  assign Busy     = (state != ST_IDLE);
  assign bufWrite = (state == ST_FILL) && DataValid;

  // wrCount doubles as LEN: it is frozen from leaving FILL until the CHK handshake.
  assign fillDone  = !pending && ((wrCount == MaxLen) || (!DataReadyToSend && wrCount != 8'd0));
  assign fillEmpty = !pending && (wrCount == 8'd0) && !DataReadyToSend;

  always_ff @(posedge Clock) begin
    if (!Reset_n) state <= ST_IDLE;
    else          state <= stateNext;
  end

  always_comb begin
    stateNext  = state;
    ReadEnable = 1'b0;
    TxValid    = 1'b0;
    txDataNext = TxData;
    rdIdxNext  = rdIdx;
    packetDone = 1'b0;
    case (state)
      ST_IDLE: begin
        if (DataReadyToSend) stateNext = ST_FILL;
      end
      ST_FILL: begin
        ReadEnable = DataReadyToSend &&
                     (({1'b0, wrCount} + {8'd0, pending}) < {1'b0, MaxLen});
        if (fillDone) begin
          stateNext  = ST_HDR;
          txDataNext = SYNC_BYTE;
        end else if (fillEmpty) begin
          stateNext = ST_IDLE;
        end
      end
      ST_HDR: begin
        TxValid = 1'b1;
        if (TxReady) begin
          stateNext  = ST_SEQ;
          txDataNext = seqNum;
        end
      end
      ST_SEQ: begin
        TxValid = 1'b1;
        if (TxReady) begin
          stateNext  = ST_LEN;
          txDataNext = wrCount;
        end
      end
      ST_LEN: begin
        TxValid = 1'b1;
        if (TxReady) begin
          stateNext  = ST_PAYLOAD;
          txDataNext = bufData;
          rdIdxNext  = rdIdx + 8'd1;
        end
      end
      ST_PAYLOAD: begin
        TxValid = 1'b1;
        if (TxReady) begin
          if (rdIdx == wrCount) begin
            stateNext  = ST_CHK;
            txDataNext = chkAdd(chkAdd(checksum, seqNum), wrCount);
          end else begin
            txDataNext = bufData;
            rdIdxNext  = rdIdx + 8'd1;
          end
        end
      end
      ST_CHK: begin
        TxValid = 1'b1;
        if (TxReady) begin
          packetDone = 1'b1;
          rdIdxNext  = 8'd0;
          stateNext  = DataReadyToSend ? ST_FILL : ST_IDLE;
        end
      end
      default: stateNext = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      TxData   <= 8'd0;
      seqNum   <= 8'd0;
      wrCount  <= 8'd0;
      pending  <= 1'b0;
      checksum <= 8'd0;
      rdIdx    <= 8'd0;
    end else begin
      TxData  <= txDataNext;
      pending <= ReadEnable;
      rdIdx   <= rdIdxNext;
      if (bufWrite) begin
        wrCount  <= wrCount + 8'd1;
        checksum <= chkAdd(checksum, DataIn);
      end
      if (packetDone) begin
        seqNum   <= seqNum + 8'd1;
        wrCount  <= 8'd0;
        checksum <= 8'd0;
      end
    end
  end

  // Read address tracks rdIdxNext so bufData always equals buffer[rdIdx]: the prefetch
  // that lets payload bytes leave back-to-back.
  packet_buffer #(.DEPTH(PAYLOAD_MAX), .AW(AW)) u_buffer (
    .Clock      (Clock),
    .WriteEnable(bufWrite),
    .WriteAddr  (wrCount[AW-1:0]),
    .WriteData  (DataIn),
    .ReadAddr   (rdIdxNext[AW-1:0]),
    .ReadData   (bufData)
  );

endmodule

// File: tb/tb_data_packetizer.sv
// Directed bench: a queue-backed storage model feeds the packetizer, a monitor captures
// accepted Tx bytes, and each scenario compares them with hand-computed packets.
module tb_data_packetizer;

  logic       Clock;
  logic       Reset_n;
  logic       DataReadyToSend;
  logic [7:0] DataIn;
  logic       DataValid;
  logic       ReadEnable;
  logic [7:0] TxData;
  logic       TxValid;
  logic       TxReady;
  logic       Busy;

  int vecCount  = 0;
  int missCount = 0;
  int cycle     = 0;
  int phase     = 0;

  logic [7:0] storeQ[$];
  logic [7:0] rxQ[$];
  logic [7:0] expQ[$];
  int         rxCyc[$];
  logic       reqSeen     = 1'b0;
  logic       readyToggle = 1'b0;
  logic       stallPrev   = 1'b0;
  logic [7:0] heldData    = 8'd0;

  data_packetizer #(.PAYLOAD_MAX(64), .SYNC_BYTE(8'hA5)) dut (
    .Clock          (Clock),
    .Reset_n        (Reset_n),
    .DataReadyToSend(DataReadyToSend),
    .DataIn         (DataIn),
    .DataValid      (DataValid),
    .ReadEnable     (ReadEnable),
    .TxData         (TxData),
    .TxValid        (TxValid),
    .TxReady        (TxReady),
    .Busy           (Busy)
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  always @(posedge Clock) cycle++;

  task automatic checkVec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecCount++;
    if (obs !== exp) begin
      missCount++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  // Storage model: the byte requested by ReadEnable shows up one cycle later.
  always @(negedge Clock) reqSeen = ReadEnable;

  initial begin
    DataValid       = 1'b0;
    DataIn          = 8'd0;
    DataReadyToSend = 1'b0;
    forever begin
      @(posedge Clock);
      #1;
      if (reqSeen === 1'b1 && storeQ.size() > 0) begin
        DataValid = 1'b1;
        DataIn    = storeQ.pop_front();
      end else begin
        DataValid = 1'b0;
      end
      DataReadyToSend = (storeQ.size() > 0);
    end
  end

  initial begin
    TxReady = 1'b1;
    forever begin
      @(posedge Clock);
      #1;
      if (readyToggle) begin
        TxReady = (phase == 0);
        phase   = (phase + 1) % 3;
      end else begin
        TxReady = 1'b1;
      end
    end
  end

  always @(negedge Clock) begin
    if (Reset_n === 1'b1 && TxValid === 1'b1) begin
      if (stallPrev) checkVec("stall_hold", TxData, heldData);
      if (TxReady === 1'b1) begin
        rxQ.push_back(TxData);
        rxCyc.push_back(cycle);
      end
      stallPrev = (TxReady !== 1'b1);
      heldData  = TxData;
    end else begin
      stallPrev = 1'b0;
    end
  end

  task automatic clearQs();
    rxQ.delete();
    rxCyc.delete();
    expQ.delete();
  endtask

  task automatic doReset();
    @(posedge Clock);
    #2 Reset_n = 1'b0;
    repeat (2) @(posedge Clock);
    #2 Reset_n = 1'b1;
  endtask

  task automatic expHdr(input logic [7:0] seq, input logic [7:0] len);
    expQ.push_back(8'hA5);
    expQ.push_back(seq);
    expQ.push_back(len);
  endtask

  task automatic drain(input string tag, input int budget);
    int n = 0;
    logic [31:0] o;
    while (!(rxQ.size() >= expQ.size() && Busy === 1'b0) && n < budget) begin
      @(negedge Clock);
      #1;
      n++;
    end
    checkVec({tag, "_busy"}, Busy, 0);
    checkVec({tag, "_count"}, rxQ.size(), expQ.size());
    for (int i = 0; i < expQ.size(); i++) begin
      o = (i < rxQ.size()) ? 32'(rxQ[i]) : 32'hDEAD;
      checkVec($sformatf("%s_b%0d", tag, i), o, expQ[i]);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] chkTab[4];
    logic [7:0] b;
    int n;
    int len;
    chkTab = '{8'h20, 8'h21, 8'h22, 8'h27};

    Reset_n = 1'b0;
    repeat (3) @(posedge Clock);
    @(negedge Clock);
    checkVec("rst_txvalid", TxValid, 0);
    checkVec("rst_busy", Busy, 0);
    checkVec("rst_readen", ReadEnable, 0);
    checkVec("rst_txdata", TxData, 0);
    #1 Reset_n = 1'b1;

    // Three-byte packet, TxReady held high.
    clearQs();
    storeQ.push_back(8'h01); storeQ.push_back(8'h02); storeQ.push_back(8'h03);
    expQ = '{8'hA5, 8'h00, 8'h03, 8'h01, 8'h02, 8'h03, 8'h09};
    drain("t3byte", 100);
    checkVec("t3byte_span", (rxCyc.size() >= 7) ? rxCyc[6] - rxCyc[0] : -1, 6);

    // 200 incrementing bytes split into 64/64/64/8.
    doReset();
    clearQs();
    for (int i = 0; i < 200; i++) storeQ.push_back(8'(i));
    for (int p = 0; p < 4; p++) begin
      len = (p < 3) ? 64 : 8;
      expHdr(8'(p), 8'(len));
      for (int j = 0; j < len; j++) expQ.push_back(8'(p * 64 + j));
      expQ.push_back(chkTab[p]);
    end
    drain("t200", 3000);

    // Stalling downstream: 1 cycle ready, 2 cycles not.
    doReset();
    clearQs();
    phase       = 0;
    readyToggle = 1'b1;
    for (int i = 1; i <= 10; i++) storeQ.push_back(8'(i));
    expHdr(8'h00, 8'h0A);
    for (int i = 1; i <= 10; i++) expQ.push_back(8'(i));
    expQ.push_back(8'h41);
    drain("tstall", 400);
    readyToggle = 1'b0;

    // Source runs dry with the sixth read still in flight.
    doReset();
    clearQs();
    storeQ.push_back(8'h11); storeQ.push_back(8'h22); storeQ.push_back(8'h33);
    storeQ.push_back(8'h44); storeQ.push_back(8'h55); storeQ.push_back(8'h66);
    expQ = '{8'hA5, 8'h00, 8'h06, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h6B};
    drain("tdry", 100);
    checkVec("tdry_span", (rxCyc.size() >= 10) ? rxCyc[9] - rxCyc[0] : -1, 9);

    // 257 one-byte packets: payload k, CHK = 2k+1; the 257th has SEQ 00 again.
    doReset();
    for (int k = 0; k <= 256; k++) begin
      clearQs();
      b = (k < 256) ? 8'(k) : 8'h5A;
      storeQ.push_back(b);
      expHdr(8'(k), 8'h01);
      expQ.push_back(b);
      expQ.push_back((k < 256) ? 8'(2 * k + 1) : 8'h5B);
      drain($sformatf("tseq%0d", k), 60);
    end

    // Reset while the tenth payload byte is on the bus.
    doReset();
    clearQs();
    for (int i = 0; i < 20; i++) storeQ.push_back(8'(i));
    n = 0;
    while (rxQ.size() < 12 && n < 300) begin
      @(posedge Clock);
      #2;
      n++;
    end
    checkVec("trst_reach", rxQ.size(), 12);
    Reset_n = 1'b0;
    @(posedge Clock);
    @(negedge Clock);
    checkVec("trst_txvalid", TxValid, 0);
    checkVec("trst_busy", Busy, 0);
    checkVec("trst_txdata", TxData, 0);
    #1 Reset_n = 1'b1;
    clearQs();
    storeQ.push_back(8'h40); storeQ.push_back(8'h41);
    expQ = '{8'hA5, 8'h00, 8'h02, 8'h40, 8'h41, 8'h83};
    drain("trst_next", 100);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
